// File: rtl/sonuc_toplayici_if.sv
// Result-stream bus between the upstream checker, the result collector and its sink.
// slave is the collector's view; master is the view of whoever drives the stream and sink.
interface sonuc_toplayici_if #(
   parameter int WORD_WIDTH = 7,
   parameter int CW         = 5
);
   logic                  i_valid;
   logic [WORD_WIDTH-1:0] i_data;
   logic                  i_frame_done;
   logic                  i_ready;
   logic                  o_valid;
   logic [WORD_WIDTH-2:0] o_data;
   logic                  o_err;
   logic                  o_frame_valid;
   logic [CW-1:0]         o_frame_words;
   logic [CW-1:0]         o_frame_errs;
   logic                  o_frame_pass;
   logic                  o_overflow;

   modport master (
      output i_valid, i_data, i_frame_done, i_ready,
      input  o_valid, o_data, o_err, o_frame_valid, o_frame_words, o_frame_errs,
             o_frame_pass, o_overflow
   );

   modport slave (
      input  i_valid, i_data, i_frame_done, i_ready,
      output o_valid, o_data, o_err, o_frame_valid, o_frame_words, o_frame_errs,
             o_frame_pass, o_overflow
   );
endinterface

// File: rtl/sonuc_toplayici.sv
// Result collector: buffers {err,data} words for a valid/ready sink and publishes
// a one-cycle pass/fail summary of each frame on the frame-done strobe.
module sonuc_toplayici #(
   parameter int WORD_WIDTH = 7,
   parameter int FRAME_LEN  = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int CW         = 5
) (
   input logic               i_clk,
   input logic               i_rstn,
   sonuc_toplayici_if.slave  bus
);
   localparam int              AW           = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]     FULL_COUNT   = FIFO_DEPTH[AW:0];
   localparam logic [CW-1:0]   CNT_MAX      = '1;
   localparam logic [CW-1:0]   FRAME_TARGET = FRAME_LEN[CW-1:0];

   typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;

   state_t                state;
   logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           count;
   logic [CW-1:0]         words;
   logic [CW-1:0]         errs;
   logic [CW-1:0]         words_next;
   logic [CW-1:0]         errs_next;
   logic                  full;
   logic                  empty;
   logic                  accept;
   logic                  drop;
   logic                  pop;
   logic                  word_err;
   logic                  overflow_next;

   // Full is judged on the occupancy before this cycle's read, so a read never rescues a write.
   assign full          = (count == FULL_COUNT);
   assign empty         = (count == '0);
   assign accept        = bus.i_valid & ~full;
   assign drop          = bus.i_valid & full;
   assign pop           = ~empty & (~bus.o_valid | bus.i_ready);
   assign word_err      = bus.i_data[WORD_WIDTH-1];
   assign overflow_next = bus.o_overflow | drop;

   always_comb begin
      words_next = words;
      errs_next  = errs;
      if (accept) begin
         if (words != CNT_MAX) words_next = words + 1'b1;
         if (word_err && (errs != CNT_MAX)) errs_next = errs + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (accept) mem[wr_ptr] <= bus.i_data;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         bus.o_valid <= 1'b0;
         bus.o_data  <= '0;
         bus.o_err   <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (pop) begin
            bus.o_valid              <= 1'b1;
            {bus.o_err, bus.o_data}  <= mem[rd_ptr];
         end else if (bus.i_ready) begin
            bus.o_valid <= 1'b0;
         end
      end
   end

   // A word or drop landing in the REPORT cycle already belongs to the next frame.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state             <= IDLE;
         words             <= '0;
         errs              <= '0;
         bus.o_overflow    <= 1'b0;
         bus.o_frame_valid <= 1'b0;
         bus.o_frame_words <= '0;
         bus.o_frame_errs  <= '0;
         bus.o_frame_pass  <= 1'b0;
      end else begin
         bus.o_frame_valid <= 1'b0;
         case (state)
            IDLE, COLLECT: begin
               words          <= words_next;
               errs           <= errs_next;
               bus.o_overflow <= overflow_next;
               if (bus.i_frame_done) begin
                  state             <= REPORT;
                  bus.o_frame_valid <= 1'b1;
                  bus.o_frame_words <= words_next;
                  bus.o_frame_errs  <= errs_next;
                  bus.o_frame_pass  <= (errs_next == '0) && (words_next == FRAME_TARGET)
                                       && !overflow_next;
               end else if (accept) begin
                  state <= COLLECT;
               end
            end
            REPORT: begin
               words          <= CW'(accept);
               errs           <= CW'(accept & word_err);
               bus.o_overflow <= drop;
               state          <= accept ? COLLECT : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sonuc_toplayici.sv
// Directed self-checking bench for the result collector: stream order/latency,
// back-pressure overflow, frame summaries and strobe boundary cases.
module tb_sonuc_toplayici;
   logic clk;
   logic rstn;
   int   checks   = 0;
   int   failures = 0;

   sonuc_toplayici_if #(.WORD_WIDTH(7), .CW(5)) bus ();

   sonuc_toplayici #(
      .WORD_WIDTH(7),
      .FRAME_LEN(16),
      .FIFO_DEPTH(8),
      .CW(5)
   ) dut (
      .i_clk(clk),
      .i_rstn(rstn),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of upstream inputs; returns just after the edge that sampled them.
   task automatic applyStimulus(input logic v, input logic [6:0] d, input logic fd);
      bus.i_valid      = v;
      bus.i_data       = d;
      bus.i_frame_done = fd;
      tick();
   endtask

   task automatic checkSummary(input string name, input int w, input int e, input logic p);
      checkOutput({name, " frame_valid"}, bus.o_frame_valid, 1);
      checkOutput({name, " frame_words"}, bus.o_frame_words, w[4:0]);
      checkOutput({name, " frame_errs"},  bus.o_frame_errs,  e[4:0]);
      checkOutput({name, " frame_pass"},  bus.o_frame_pass,  p);
   endtask

   // One word every 4 cycles with the sink ready; each word must surface one edge after acceptance.
   task automatic runFrame(input int n, input logic [15:0] errMask, input string name);
      for (int k = 0; k < n; k++) begin
         logic [6:0] w;
         w = {errMask[k], 6'(k)};
         applyStimulus(1'b1, w, 1'b0);
         applyStimulus(1'b0, 7'h00, 1'b0);
         checkOutput({name, " o_valid"}, bus.o_valid, 1);
         checkOutput({name, " o_data"},  bus.o_data,  w[5:0]);
         checkOutput({name, " o_err"},   bus.o_err,   errMask[k]);
         applyStimulus(1'b0, 7'h00, 1'b0);
         checkOutput({name, " drained"}, bus.o_valid, 0);
         applyStimulus(1'b0, 7'h00, 1'b0);
      end
   endtask

   initial begin
      // Reset held with busy inputs
      rstn             = 1'b0;
      bus.i_valid      = 1'b1;
      bus.i_data       = 7'h3F;
      bus.i_frame_done = 1'b1;
      bus.i_ready      = 1'b1;
      tick();
      tick();
      checkOutput("rst o_valid",       bus.o_valid,       0);
      checkOutput("rst o_data",        bus.o_data,        0);
      checkOutput("rst o_err",         bus.o_err,         0);
      checkOutput("rst frame_valid",   bus.o_frame_valid, 0);
      checkOutput("rst frame_words",   bus.o_frame_words, 0);
      checkOutput("rst frame_errs",    bus.o_frame_errs,  0);
      checkOutput("rst frame_pass",    bus.o_frame_pass,  0);
      checkOutput("rst overflow",      bus.o_overflow,    0);
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 7'h00, 1'b0);
         checkOutput("post-rst frame_valid", bus.o_frame_valid, 0);
         checkOutput("post-rst o_valid",     bus.o_valid,       0);
      end

      // Clean 16-word frame
      runFrame(16, 16'h0000, "clean");
      applyStimulus(1'b0, 7'h00, 1'b1);
      checkSummary("clean", 16, 0, 1'b1);
      checkOutput("clean overflow", bus.o_overflow, 0);
      applyStimulus(1'b0, 7'h00, 1'b0);
      checkOutput("clean strobe width", bus.o_frame_valid, 0);
      checkOutput("clean words hold",   bus.o_frame_words, 16);

      // Errors on words 3 and 9
      runFrame(16, 16'h0208, "errframe");
      applyStimulus(1'b0, 7'h00, 1'b1);
      checkSummary("errframe", 16, 2, 1'b0);
      applyStimulus(1'b0, 7'h00, 1'b0);

      // Stalled sink: 10 back-to-back words into 8 FIFO slots plus the output register
      bus.i_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, 7'h10 + 7'(k), 1'b0);
         if (k == 8) checkOutput("bp no overflow yet", bus.o_overflow, 0);
      end
      checkOutput("bp overflow",    bus.o_overflow, 1);
      checkOutput("bp frozen valid", bus.o_valid,   1);
      checkOutput("bp frozen data", bus.o_data,     6'h10);
      applyStimulus(1'b0, 7'h00, 1'b0);
      checkOutput("bp still frozen", bus.o_data,    6'h10);
      bus.i_ready = 1'b1;
      for (int j = 0; j < 9; j++) begin
         checkOutput("bp drain valid", bus.o_valid, 1);
         checkOutput("bp drain data",  bus.o_data,  6'h10 + 6'(j));
         applyStimulus(1'b0, 7'h00, 1'b0);
      end
      checkOutput("bp drained", bus.o_valid, 0);
      applyStimulus(1'b0, 7'h00, 1'b1);
      checkSummary("bp", 9, 0, 1'b0);
      checkOutput("bp overflow in report", bus.o_overflow, 1);
      applyStimulus(1'b0, 7'h00, 1'b0);
      checkOutput("bp overflow cleared", bus.o_overflow, 0);

      // Word on the frame-done cycle closes with that frame
      applyStimulus(1'b1, 7'h05, 1'b1);
      checkSummary("same-cycle", 1, 0, 1'b0);
      // Error word during REPORT, with a frame-done strobe that must be ignored
      applyStimulus(1'b1, 7'h47, 1'b1);
      checkOutput("report strobe ignored", bus.o_frame_valid, 0);
      checkOutput("report errs hold",      bus.o_frame_errs,  0);
      applyStimulus(1'b0, 7'h00, 1'b1);
      checkSummary("word-in-report", 1, 1, 1'b0);
      applyStimulus(1'b0, 7'h00, 1'b0);

      // Frame-done with nothing collected
      applyStimulus(1'b0, 7'h00, 1'b1);
      checkSummary("empty", 0, 0, 1'b0);
      applyStimulus(1'b0, 7'h00, 1'b0);

      // One word short
      runFrame(15, 16'h0000, "short");
      applyStimulus(1'b0, 7'h00, 1'b1);
      checkSummary("short", 15, 0, 1'b0);
      applyStimulus(1'b0, 7'h00, 1'b0);

      // 33 error words back-to-back: both counters pin at 31
      for (int k = 0; k < 33; k++) applyStimulus(1'b1, {1'b1, 6'(k)}, 1'b0);
      applyStimulus(1'b0, 7'h00, 1'b1);
      checkSummary("saturate", 31, 31, 1'b0);
      checkOutput("saturate overflow", bus.o_overflow, 0);
      applyStimulus(1'b0, 7'h00, 1'b0);
      applyStimulus(1'b0, 7'h00, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
